// File: rtl/wb_stream_writer_pkg.sv
// Shared definitions for the stream-to-Wishbone burst writer:
// cycle-type codes, FSM state encoding and a small helper.
package wb_stream_writer_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_BURST     = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/wb_stream_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers and count clear on rst.
module wb_stream_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_stream_writer.sv
// Wishbone write master: buffers a valid/ready word stream and writes it to
// consecutive words in incrementing bursts that never cross a burst-aligned boundary.
//
//   state     | meaning
//   IDLE      | waiting for start
//   WAIT_DATA | waiting until the next burst's words are buffered
//   BURST     | cyc/stb high, one beat per ack
//   DONE      | one-cycle done pulse
module wb_stream_writer
  import wb_stream_writer_pkg::*;
#(
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [31:0]      base_adr,
  input  logic [CNT_W-1:0] length,
  output logic             busy,
  output logic             done,
  input  logic [31:0]      s_dat,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  output logic [2:0]       wbm_cti_o,
  output logic [3:0]       wbm_sel_o,
  output logic             wbm_we_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  input  logic             wbm_ack_i
);

  localparam int NW = $clog2(BURST_LEN + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t           state, state_nxt;
  logic [31:0]      adr_q;
  logic [CNT_W-1:0] remaining, len_q, accepted;
  logic [NW-1:0]    burst_n, beat;
  logic [31:0]      to_bnd, n32;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full, fifo_empty;
  logic             push, pop, data_ready, last_beat;
  logic             unused_dat;

  assign unused_dat = ^wbm_dat_i;

  // Beats left before the next BURST_LEN-word aligned boundary.
  always_comb begin
    to_bnd     = 32'(BURST_LEN) - (32'(adr_q[31:2]) & 32'(BURST_LEN - 1));
    n32        = min_u32(to_bnd, 32'(remaining));
    data_ready = (32'(fifo_count) >= n32);
  end

  assign last_beat = (beat == burst_n - NW'(1));
  assign push      = s_valid & s_ready;
  assign pop       = (state == ST_BURST) & wbm_ack_i;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    wbm_cyc_o = 1'b0;
    wbm_cti_o = CTI_CLASSIC;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (length == '0) ? ST_DONE : ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        busy = 1'b1;
        if (data_ready) state_nxt = ST_BURST;
      end
      ST_BURST: begin
        busy      = 1'b1;
        wbm_cyc_o = 1'b1;
        if (burst_n != NW'(1)) wbm_cti_o = last_beat ? CTI_END : CTI_INCR;
        if (wbm_ack_i && last_beat)
          state_nxt = (remaining == CNT_W'(1)) ? ST_DONE : ST_WAIT_DATA;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign s_ready   = busy & ~fifo_full & (accepted != len_q);
  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_we_o  = wbm_cyc_o;
  assign wbm_sel_o = 4'hF;
  assign wbm_adr_o = adr_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      adr_q     <= '0;
      remaining <= '0;
      len_q     <= '0;
      accepted  <= '0;
      burst_n   <= '0;
      beat      <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        adr_q     <= base_adr & 32'hFFFF_FFFC;
        remaining <= length;
        len_q     <= length;
        accepted  <= '0;
      end
      if (push) accepted <= accepted + CNT_W'(1);
      if (state == ST_WAIT_DATA && data_ready) begin
        burst_n <= NW'(n32);
        beat    <= '0;
      end
      if (pop) begin
        adr_q     <= adr_q + 32'd4;
        remaining <= remaining - CNT_W'(1);
        beat      <= beat + NW'(1);
      end
    end
  end

  wb_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (push),
    .din   (s_dat),
    .pop   (pop),
    .dout  (wbm_dat_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_wb_stream_writer.sv
// Self-checking bench for wb_stream_writer: random stream data, a word-level
// burst-splitting model and a cycle-by-cycle Wishbone slave/stream source.
module tb_wb_stream_writer;

  localparam int BL = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_adr = '0;
  logic [15:0] length = '0;
  logic        busy, done;
  logic [31:0] s_dat = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = 32'hA5A5_5A5A;
  logic [2:0]  wbm_cti_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic        wbm_ack_i = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  wb_stream_writer #(.BURST_LEN(BL), .FIFO_DEPTH(8), .CNT_W(16)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .base_adr  (base_adr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .s_dat     (s_dat),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_cti_o (wbm_cti_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_ack_i (wbm_ack_i)
  );

  // Runs one transfer. ws<0 picks random wait states per beat; gap is idle
  // cycles between stream words; abort_at>=0 asserts reset while that beat is on the bus.
  task automatic run_xfer(input string name, input logic [31:0] base, input int len,
                          input int ws, input int gap, input bit poke, input int abort_at);
    logic [31:0] data_q[$];
    logic [31:0] e_adr[$];
    logic [31:0] e_dat[$];
    logic [2:0]  e_cti[$];
    bit          e_end[$];
    int          e_n[$];
    logic [31:0] a;
    int w, sidx, idx, wcnt, wtarget, gcnt, cyc_exp;
    bit done_seen;

    a = base & 32'hFFFF_FFFC;
    w = 0;
    for (int i = 0; i < len; i++) data_q.push_back($urandom);
    while (w < len) begin
      int off;
      int n;
      off = int'((a >> 2) % BL);
      n = BL - off;
      if (len - w < n) n = len - w;
      for (int k = 0; k < n; k++) begin
        e_adr.push_back(a);
        e_dat.push_back(data_q[w]);
        e_cti.push_back((n == 1) ? 3'b000 : ((k == n - 1) ? 3'b111 : 3'b010));
        e_end.push_back(k == n - 1);
        e_n.push_back(n);
        a = a + 32'd4;
        w++;
      end
    end

    @(negedge sys_clk);
    start = 1'b1; base_adr = base; length = 16'(len);
    @(negedge sys_clk);
    start = 1'b0;

    sidx = 0; idx = 0; wcnt = 0; gcnt = 0; cyc_exp = 0; done_seen = 1'b0;
    wtarget = (ws >= 0) ? ws : int'($urandom_range(0, 3));
    for (int cyc_n = 0; cyc_n < 4000 && !done_seen; cyc_n++) begin
      checks++;
      if (wbm_cyc_o !== cyc_exp[0]) begin
        errors++;
        $display("FAIL %s cyc_seq cycle %0d: got %b want %0d", name, cyc_n, wbm_cyc_o, cyc_exp);
      end
      checks++;
      if (wbm_stb_o !== wbm_cyc_o || wbm_we_o !== wbm_cyc_o || wbm_sel_o !== 4'hF) begin
        errors++;
        $display("FAIL %s stb_we_sel: stb %b we %b sel %h cyc %b want stb=we=cyc sel F",
                 name, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_cyc_o);
      end
      if (sidx == len) begin
        checks++;
        if (s_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s s_ready_after_len: got %b want 0", name, s_ready);
        end
      end
      if (poke && cyc_n == 2) begin
        start = 1'b1; base_adr = 32'hDEAD_BEE0; length = 16'd3;
      end else if (poke && cyc_n == 3) begin
        start = 1'b0;
      end

      if (abort_at >= 0 && wbm_cyc_o === 1'b1 && idx == abort_at) begin
        sys_rst = 1'b1; wbm_ack_i = 1'b0; s_valid = 1'b0;
        @(negedge sys_clk);
        checks++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, busy, done, s_ready} !== 6'b0 ||
            wbm_adr_o !== 32'd0 || wbm_cti_o !== 3'b000) begin
          errors++;
          $display("FAIL %s reset_mid_burst: cyc %b stb %b we %b busy %b done %b rdy %b adr %h cti %b want all 0",
                   name, wbm_cyc_o, wbm_stb_o, wbm_we_o, busy, done, s_ready, wbm_adr_o, wbm_cti_o);
        end
        sys_rst = 1'b0;
        return;
      end

      if (done === 1'b1) begin
        done_seen = 1'b1;
        checks++;
        if (busy !== 1'b0 || idx != len) begin
          errors++;
          $display("FAIL %s done_point: busy %b beats %0d want busy 0 beats %0d", name, busy, idx, len);
        end
        if (poke) begin
          start = 1'b1; base_adr = 32'h0000_0800; length = 16'd4;
        end
      end else begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy_during: got %b want 1", name, busy);
        end
      end

      wbm_ack_i = 1'b0;
      if (wbm_cyc_o === 1'b1) begin
        if (idx >= len) begin
          checks++; errors++;
          $display("FAIL %s extra_beat: adr %h beyond %0d words", name, wbm_adr_o, len);
          cyc_exp = 0;
        end else begin
          checks++;
          if (wbm_adr_o !== e_adr[idx] || wbm_dat_o !== e_dat[idx] || wbm_cti_o !== e_cti[idx]) begin
            errors++;
            $display("FAIL %s beat %0d: adr %h dat %h cti %b want adr %h dat %h cti %b", name, idx,
                     wbm_adr_o, wbm_dat_o, wbm_cti_o, e_adr[idx], e_dat[idx], e_cti[idx]);
          end
          if (wcnt == wtarget) begin
            wbm_ack_i = 1'b1;
            cyc_exp = e_end[idx] ? 0 : 1;
            idx++;
            wcnt = 0;
            wtarget = (ws >= 0) ? ws : int'($urandom_range(0, 3));
          end else begin
            wcnt++;
            cyc_exp = 1;
          end
        end
      end else if (busy === 1'b1 && idx < len) begin
        cyc_exp = ((sidx - idx) >= e_n[idx]) ? 1 : 0;
      end else begin
        cyc_exp = 0;
      end

      s_valid = (sidx < len) && (gcnt == 0);
      s_dat = (sidx < len) ? data_q[sidx] : 32'd0;
      if (s_valid && s_ready === 1'b1) begin
        sidx++;
        gcnt = gap;
      end else if (gcnt > 0) begin
        gcnt--;
      end
      @(negedge sys_clk);
    end

    wbm_ack_i = 1'b0; s_valid = 1'b0;
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL %s timeout: beats %0d words %0d want %0d", name, idx, sidx, len);
    end
    checks++;
    if (sidx != len || idx != len) begin
      errors++;
      $display("FAIL %s consumed: words %0d beats %0d want %0d", name, sidx, idx, len);
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || wbm_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: done %b busy %b cyc %b want 0 0 0", name, done, busy, wbm_cyc_o);
    end
    start = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: busy %b done %b want 0 0", name, busy, done);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({busy, done, s_ready, wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 6'b0 ||
        wbm_cti_o !== 3'b000 || wbm_adr_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy %b done %b rdy %b cyc %b stb %b we %b cti %b adr %h want all 0",
               busy, done, s_ready, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cti_o, wbm_adr_o);
    end
    sys_rst = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic test_zero_length();
    start = 1'b1; base_adr = 32'h0000_0400; length = 16'd0;
    @(negedge sys_clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || wbm_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_done: done %b busy %b cyc %b want 1 0 0", done, busy, wbm_cyc_o);
    end
    @(negedge sys_clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || wbm_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_after: done %b busy %b cyc %b want 0 0 0", done, busy, wbm_cyc_o);
    end
  endtask

  task automatic test_two_bursts();
    run_xfer("two_bursts", 32'h0000_0100, 8, 0, 0, 1'b0, -1);
  endtask

  task automatic test_unaligned();
    run_xfer("unaligned_5", 32'h0000_0108, 5, 0, 0, 1'b0, -1);
    run_xfer("unaligned_2", 32'h0000_0108, 2, 0, 0, 1'b0, -1);
    run_xfer("unaligned_3", 32'h0000_010B, 3, 0, 0, 1'b0, -1);
  endtask

  task automatic test_single();
    run_xfer("single", 32'h0000_0204, 1, 0, 0, 1'b0, -1);
    test_zero_length();
  endtask

  task automatic test_wait_states();
    run_xfer("wait_states", 32'h0000_0040, 6, 3, 0, 1'b0, -1);
  endtask

  task automatic test_stream_stall();
    run_xfer("stream_stall", 32'h0000_0300, 7, 0, 4, 1'b0, -1);
  endtask

  task automatic test_reset_mid_burst();
    run_xfer("abort", 32'h0000_0100, 8, 0, 0, 1'b0, 1);
    run_xfer("after_abort", 32'h0000_0500, 6, 1, 0, 1'b0, -1);
  endtask

  task automatic test_start_ignored();
    run_xfer("start_ignored", 32'h0000_0600, 8, 1, 1, 1'b1, -1);
  endtask

  task automatic test_addr_wrap();
    run_xfer("addr_wrap", 32'hFFFF_FFF8, 6, 0, 0, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_xfer($sformatf("random_%0d", i), $urandom & 32'h0000_FFFF,
               int'($urandom_range(1, 20)), -1, int'($urandom_range(0, 3)), 1'b0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_two_bursts();
    test_unaligned();
    test_single();
    test_wait_states();
    test_stream_stall();
    test_reset_mid_burst();
    test_start_ignored();
    test_addr_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
